pll_reset_seq: RTL and testbench

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

---
 rtl/pll_pkg.sv | 19 +
 rtl/sync_2ff.sv | 26 ++
 rtl/pll_reset_seq.sv | 109 ++++++++++
 tb/tb_pll_reset_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_pkg;

  typedef enum logic [1:0] {
    StResetPll,
    StWaitLock,
    StStable,
    StRun
  } state_e;

  localparam int unsigned RETRY_MAX = 15;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing asynchronous levels into the clk domain.
module sync_2ff #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock and then
// releases the core-domain reset; retries on lock timeout.
module pll_reset_seq
  import pll_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic [3:0] retry_cnt,
  output logic       lock_lost
);

  if (RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1) begin : g_param_check
    $error("pll_reset_seq: RST_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES must all be >= 1");
  end

  localparam int MaxCycles = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [CntW-1:0] RstLast    = CntW'(RST_CYCLES - 1);
  localparam logic [CntW-1:0] LockLast   = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] StableLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [3:0]      RetryMax   = 4'(RETRY_MAX);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      retry_q, retry_d;
  logic            lost_q, lost_d;
  logic            locked_s;

  sync_2ff #(
    .Width(1)
  ) u_lock_sync (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (locked),
    .q_o  (locked_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StResetPll;
      cnt_q   <= '0;
      retry_q <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      lost_q  <= lost_d;
    end
  end

  // The counter is cleared on every transition, so it never exceeds its terminal value.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    retry_d = retry_q;
    lost_d  = lost_q;
    unique case (state_q)
      StResetPll: begin
        if (cnt_q == RstLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end
      end
      StWaitLock: begin
        if (locked_s) begin
          state_d = StStable;
          cnt_d   = '0;
        end else if (cnt_q == LockLast) begin
          state_d = StResetPll;
          cnt_d   = '0;
          if (retry_q != RetryMax) retry_d = retry_q + 4'd1;
        end
      end
      StStable: begin
        if (!locked_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        cnt_d = '0;
        if (!locked_s) begin
          state_d = StResetPll;
          lost_d  = 1'b1;
        end
      end
    endcase
  end

  assign pll_rst   = (state_q == StResetPll);
  assign sys_reset = (state_q != StRun);
  assign ready     = (state_q == StRun);
  assign retry_cnt = retry_q;
  assign lock_lost = lost_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench for pll_reset_seq with RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8.
module tb_pll_reset_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       pll_rst, sys_reset, ready, lock_lost;
  logic [3:0] retry_cnt;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string tag;
    int    val;
  } exp_t;
  exp_t sb_q[$];

  pll_reset_seq #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .locked   (locked),
    .pll_rst  (pll_rst),
    .sys_reset(sys_reset),
    .ready    (ready),
    .retry_cnt(retry_cnt),
    .lock_lost(lock_lost)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic exp_push(input string tag, input int val);
    sb_q.push_back('{tag, val});
  endtask

  task automatic exp_pop(input int act);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", sb_q.size(), 1);
    end else begin
      e = sb_q.pop_front();
      check_val(e.tag, act, e.val);
    end
  endtask

  // Assert rst between edges and verify the reset outputs before any clock edge.
  task automatic apply_reset(input logic lk);
    @(posedge clk);
    #1;
    rst    = 1'b1;
    locked = lk;
    exp_push("rst_pll_rst", 1);
    exp_push("rst_sys_reset", 1);
    exp_push("rst_ready", 0);
    exp_push("rst_retry", 0);
    exp_push("rst_lock_lost", 0);
    #1;
    exp_pop(int'(pll_rst));
    exp_pop(int'(sys_reset));
    exp_pop(int'(ready));
    exp_pop(int'(retry_cnt));
    exp_pop(int'(lock_lost));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Sample n=0 now, then once per edge; locked driven after sample n is seen at edge n+1.
  task automatic run_to_ready(input int lock_from, input int drop_at, input int drop_len,
                              input int max_edges, output int ready_n, output int rst_hi,
                              output int pulses, output int sys_at_rdy);
    logic prev;
    prev       = 1'b1;
    ready_n    = -1;
    rst_hi     = 0;
    pulses     = 0;
    sys_at_rdy = -1;
    for (int n = 0; n <= max_edges; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      if (pll_rst) begin
        rst_hi++;
        if (!prev) pulses++;
      end
      prev = pll_rst;
      if (ready) begin
        ready_n    = n;
        sys_at_rdy = int'(sys_reset);
        break;
      end
      locked = (n >= lock_from) && !(n >= drop_at && n < drop_at + drop_len);
    end
  endtask

  task automatic scen_ready(input string name, input int lock_from, input int drop_at,
                            input int drop_len, input int e_ready, input int e_rsthi,
                            input int e_pulses, input int e_retry);
    int r_n, r_hi, r_pl, r_sys;
    exp_push({name, "_ready_edge"}, e_ready);
    exp_push({name, "_pll_rst_cycles"}, e_rsthi);
    exp_push({name, "_pll_rst_repulses"}, e_pulses);
    exp_push({name, "_retry_cnt"}, e_retry);
    exp_push({name, "_sys_reset_at_ready"}, 0);
    run_to_ready(lock_from, drop_at, drop_len, 200, r_n, r_hi, r_pl, r_sys);
    exp_pop(r_n);
    exp_pop(r_hi);
    exp_pop(r_pl);
    exp_pop(int'(retry_cnt));
    exp_pop(r_sys);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Constant lock: 4 reset cycles, 1 wait, 8 stable.
    apply_reset(1'b1);
    scen_ready("lock_const", 0, 1000, 0, 13, 4, 0, 0);

    // Lock loss in RUN: visible on the third edge after locked falls.
    locked = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      exp_push("loss_ready", (e < 3) ? 1 : 0);
      exp_push("loss_pll_rst", (e == 3) ? 1 : 0);
      exp_push("loss_sys_reset", (e == 3) ? 1 : 0);
      exp_push("loss_lock_lost", (e == 3) ? 1 : 0);
      @(posedge clk);
      #1;
      exp_pop(int'(ready));
      exp_pop(int'(pll_rst));
      exp_pop(int'(sys_reset));
      exp_pop(int'(lock_lost));
    end
    scen_ready("relock", 0, 1000, 0, 13, 4, 0, 0);
    exp_push("lock_lost_sticky", 1);
    exp_pop(int'(lock_lost));
    apply_reset(1'b1);  // async reset while in RUN clears lock_lost

    // One-cycle drop at STABLE count 5; then a drop coinciding with the terminal count.
    scen_ready("stable_drop", 0, 8, 1, 20, 4, 0, 0);
    apply_reset(1'b1);
    scen_ready("tc_drop", 0, 10, 1, 22, 4, 0, 0);

    // Two timeouts before lock.
    apply_reset(1'b0);
    scen_ready("two_retry", 50, 1000, 0, 61, 12, 2, 2);

    // Lock arriving on the timeout cycle wins.
    apply_reset(1'b0);
    scen_ready("lock_vs_timeout", 21, 1000, 0, 32, 4, 0, 0);

    // Reset mid-STABLE.
    apply_reset(1'b1);
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
    end
    exp_push("mid_stable_pll_rst", 0);
    exp_push("mid_stable_ready", 0);
    exp_pop(int'(pll_rst));
    exp_pop(int'(ready));
    apply_reset(1'b1);

    // Never lock: one timeout every 24 edges, saturating at 15.
    apply_reset(1'b0);
    for (int n = 0; n <= 500; n++) begin
      exp_push("sat_retry_cnt", ((n / 24) > 15) ? 15 : (n / 24));
      exp_push("sat_pll_rst", ((n % 24) < 4) ? 1 : 0);
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      exp_pop(int'(retry_cnt));
      exp_pop(int'(pll_rst));
    end
    apply_reset(1'b0);

    check_val("sb_leftover", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
